// File: rtl/fixedpoint_pkg.sv
// Purpose: shared fixed-point number format used by the ray-math multiplier
//          and divider (two's complement, sign in bit WIDTH-1).
// Contents: WIDTH, FRAC_BITS, number typedef, MAX_POS / MAX_NEG saturation values.
package fixedpoint;

  localparam int unsigned FRAC_BITS = 32;
  localparam int unsigned WIDTH     = 65;

  typedef logic [WIDTH-1:0] number;

  localparam number MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam number MAX_NEG = {1'b1, {(WIDTH-1){1'b0}}};

endpackage : fixedpoint

// File: rtl/fixedpoint_abs.sv
// Purpose: combinational conditional two's-complement negation. With neg_i tied
//          to a_i's sign bit it yields the unsigned magnitude (|-2^(W-1)| = 2^(W-1)
//          still fits as an unsigned W-bit value).
// Ports:   a_i   W-bit operand
//          neg_i negate when 1
//          y_o   W-bit result
module fixedpoint_abs #(
  parameter int unsigned W = fixedpoint::WIDTH
) (
  input  logic [W-1:0] a_i,
  input  logic         neg_i,
  output logic [W-1:0] y_o
);

  assign y_o = neg_i ? (~a_i + W'(1)) : a_i;

endmodule : fixedpoint_abs

// File: rtl/fixedpoint_div_s.sv
// Purpose: signed fixed-point divider, quot = num1 / num2, iterative radix-2
//          restoring algorithm, one operation in flight, valid/ready on both sides.
// Ports:   clk, rst_n           clock, async active-low reset
//          in_valid / in_ready  operand handshake (in_ready high only when idle)
//          num1, num2           dividend, divisor (fixedpoint::number)
//          quot                 quotient, truncated toward zero, saturated on error
//          div_by_zero          num2 was zero
//          overflow             true quotient out of range
//          out_valid / out_ready result handshake; result held until taken
module fixedpoint_div_s #(
  parameter int unsigned FRAC = fixedpoint::FRAC_BITS,
  parameter int unsigned W    = fixedpoint::WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] num1,
  input  logic [W-1:0] num2,
  output logic [W-1:0] quot,
  output logic         div_by_zero,
  output logic         overflow,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam int unsigned N     = W - 1 + FRAC;
  localparam int unsigned CNT_W = $clog2(N);

  localparam logic [W-1:0] SAT_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SAT_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_DIV, S_FIX, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     n1_q, n1_d, n2_q, n2_d;
  logic [W-1:0]     mag2_q, mag2_d, rem_q, rem_d, quot_q, quot_d;
  logic [N-1:0]     dvd_q, dvd_d, quo_q, quo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sign_q, sign_d, dbz_q, dbz_d, ovf_q, ovf_d;

  logic [W-1:0]     mag1, mag2, neg_res, trial;
  logic [W:0]       shifted;
  logic             ge, q_pos_ovf, q_neg_ovf;

  // Operand magnitudes from the latched operands, and signed result from magnitude
  fixedpoint_abs #(.W(W)) u_abs1 (.a_i(n1_q), .neg_i(n1_q[W-1]), .y_o(mag1));
  fixedpoint_abs #(.W(W)) u_abs2 (.a_i(n2_q), .neg_i(n2_q[W-1]), .y_o(mag2));
  fixedpoint_abs #(.W(W)) u_neg  (.a_i(quo_q[W-1:0]), .neg_i(sign_q), .y_o(neg_res));

  // One restoring step: bring down the next dividend bit and trial-subtract
  assign shifted = {rem_q, dvd_q[N-1]};
  assign ge      = shifted >= {1'b0, mag2_q};
  assign trial   = shifted[W-1:0] - mag2_q;

  // Magnitude range checks: > 2^(W-1)-1 for positive, > 2^(W-1) for negative
  assign q_pos_ovf = |quo_q[N-1:W-1];
  assign q_neg_ovf = (|quo_q[N-1:W]) || (quo_q[W-1] && (|quo_q[W-2:0]));

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign quot        = quot_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

  // Next-state and datapath
  always_comb begin
    state_d = state_q;
    n1_d    = n1_q;
    n2_d    = n2_q;
    mag2_d  = mag2_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    quot_d  = quot_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          n1_d    = num1;
          n2_d    = num2;
          sign_d  = (num1[W-1] ^ num2[W-1]) & (|num1);
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        mag2_d = mag2;
        if (n2_q == '0) begin
          dbz_d   = 1'b1;
          state_d = S_FIX;
        end else begin
          dbz_d   = 1'b0;
          // |num1|<<FRAC has N+1 bits; its top bit seeds the remainder so
          // N steps cover the rest (a lost leading quotient bit implies overflow)
          rem_d   = W'(mag1[W-1]);
          dvd_d   = {mag1[W-2:0], {FRAC{1'b0}}};
          quo_d   = '0;
          cnt_d   = '0;
          state_d = S_DIV;
        end
      end
      S_DIV: begin
        rem_d = ge ? trial : shifted[W-1:0];
        dvd_d = {dvd_q[N-2:0], 1'b0};
        quo_d = {quo_q[N-2:0], ge};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_DONE;
        ovf_d   = 1'b0;
        if (dbz_q) begin
          quot_d = n1_q[W-1] ? SAT_NEG : SAT_POS;
        end else if (!sign_q && q_pos_ovf) begin
          quot_d = SAT_POS;
          ovf_d  = 1'b1;
        end else if (sign_q && q_neg_ovf) begin
          quot_d = SAT_NEG;
          ovf_d  = 1'b1;
        end else begin
          quot_d = neg_res;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      n1_q    <= '0;
      n2_q    <= '0;
      mag2_q  <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
      quot_q  <= '0;
    end else begin
      state_q <= state_d;
      n1_q    <= n1_d;
      n2_q    <= n2_d;
      mag2_q  <= mag2_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
      quot_q  <= quot_d;
    end
  end

endmodule : fixedpoint_div_s

// File: tb/tb_fixedpoint_div_s.sv
// Directed bench for fixedpoint_div_s: hand-computed quotients, saturation
// cases, latency, backpressure and mid-operation reset.
module tb_fixedpoint_div_s;

  localparam int unsigned W = 65;

  localparam logic [W-1:0] ZERO    = 65'h0;
  localparam logic [W-1:0] ONE     = 65'h0_0000_0001_0000_0000;
  localparam logic [W-1:0] TWO     = 65'h0_0000_0002_0000_0000;
  localparam logic [W-1:0] THREE   = 65'h0_0000_0003_0000_0000;
  localparam logic [W-1:0] FIVE    = 65'h0_0000_0005_0000_0000;
  localparam logic [W-1:0] SIX     = 65'h0_0000_0006_0000_0000;
  localparam logic [W-1:0] M_ONE   = 65'h1_FFFF_FFFF_0000_0000;
  localparam logic [W-1:0] M_FIVE  = 65'h1_FFFF_FFFB_0000_0000;
  localparam logic [W-1:0] M_SEVEN = 65'h1_FFFF_FFF9_0000_0000;
  localparam logic [W-1:0] LSB     = 65'h0_0000_0000_0000_0001;
  localparam logic [W-1:0] MAXP    = 65'h0_FFFF_FFFF_FFFF_FFFF;
  localparam logic [W-1:0] MAXN    = 65'h1_0000_0000_0000_0000;
  localparam logic [W-1:0] THIRD   = 65'h0_0000_0000_5555_5555;
  localparam logic [W-1:0] M_THIRD = 65'h1_FFFF_FFFF_AAAA_AAAB;
  localparam logic [W-1:0] M_3P5   = 65'h1_FFFF_FFFC_8000_0000;
  localparam logic [W-1:0] JUNK    = 65'h1_2345_6789_ABCD_EF01;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] num1;
  logic [W-1:0] num2;
  logic [W-1:0] quot;
  logic         div_by_zero;
  logic         overflow;
  logic         out_valid;
  logic         out_ready;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fixedpoint_div_s dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .num1        (num1),
    .num2        (num2),
    .quot        (quot),
    .div_by_zero (div_by_zero),
    .overflow    (overflow),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Present operands at a falling edge; returns 1 ns after the accept edge
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    @(negedge clk);
    num1     = a;
    num2     = b;
    in_valid = 1'b1;
    check({tag, "_in_ready"}, W'(in_ready), W'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    num1     = JUNK;
    num2     = ZERO;
  endtask

  // Count edges after the accept edge until out_valid, bounded
  task automatic wait_done(input int exp_lat, input string tag);
    int n = 0;
    while (out_valid !== 1'b1 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_lat"}, W'(n), W'(exp_lat));
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic edbz, input logic eovf,
                        input int lat, input string tag);
    send(a, b, tag);
    wait_done(lat, tag);
    check({tag, "_quot"}, quot, eq);
    check({tag, "_dbz"},  W'(div_by_zero), W'(edbz));
    check({tag, "_ovf"},  W'(overflow), W'(eovf));
    // out_ready is high: result transfers on the next edge
    @(posedge clk);
    #1;
    check({tag, "_xfer_valid"}, W'(out_valid), W'(0));
    check({tag, "_xfer_ready"}, W'(in_ready), W'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    num1      = ZERO;
    num2      = ZERO;
    #1;
    check("rst_in_ready",  W'(in_ready), W'(1));
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_quot",      quot, ZERO);
    check("rst_dbz",       W'(div_by_zero), W'(0));
    check("rst_ovf",       W'(overflow), W'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Normal quotients: 98 edges from accept to out_valid
    run_op(SIX,     TWO,   THREE,   1'b0, 1'b0, 98, "6div2");
    run_op(M_SEVEN, TWO,   M_3P5,   1'b0, 1'b0, 98, "m7div2");
    run_op(ONE,     THREE, THIRD,   1'b0, 1'b0, 98, "1div3");
    run_op(M_ONE,   THREE, M_THIRD, 1'b0, 1'b0, 98, "m1div3");

    // Divide by zero: out_valid on the third edge counting the accept edge
    run_op(FIVE,    ZERO,  MAXP,    1'b1, 1'b0, 2,  "5div0");
    run_op(M_FIVE,  ZERO,  MAXN,    1'b1, 1'b0, 2,  "m5div0");
    run_op(ZERO,    ZERO,  MAXP,    1'b1, 1'b0, 2,  "0div0");

    // Range limits
    run_op(MAXP,    LSB,   MAXP,    1'b0, 1'b1, 98, "maxp_div_lsb");
    run_op(MAXN,    ONE,   MAXN,    1'b0, 1'b0, 98, "maxn_div_1");
    run_op(MAXN,    M_ONE, MAXP,    1'b0, 1'b1, 98, "maxn_div_m1");

    // Backpressure: result held, second request waits until transfer
    @(negedge clk);
    out_ready = 1'b0;
    send(SIX, TWO, "bp1");
    wait_done(98, "bp1");
    @(negedge clk);
    num1     = ONE;
    num2     = THREE;
    in_valid = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
      check("bp_hold_quot",  quot, THREE);
      check("bp_hold_valid", W'(out_valid), W'(1));
      check("bp_hold_ready", W'(in_ready), W'(0));
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_xfer_valid", W'(out_valid), W'(0));
    check("bp_xfer_ready", W'(in_ready), W'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    num1     = JUNK;
    num2     = ZERO;
    check("bp2_accepted", W'(in_ready), W'(0));
    wait_done(98, "bp2");
    check("bp2_quot", quot, THIRD);
    check("bp2_dbz",  W'(div_by_zero), W'(0));
    check("bp2_ovf",  W'(overflow), W'(0));
    @(posedge clk);
    #1;
    check("bp2_xfer_valid", W'(out_valid), W'(0));

    // Reset while DIV counter is 40 (41 edges after accept)
    send(SIX, TWO, "rst_mid");
    repeat (41) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rstmid_in_ready",  W'(in_ready), W'(1));
    check("rstmid_out_valid", W'(out_valid), W'(0));
    check("rstmid_quot",      quot, ZERO);
    check("rstmid_dbz",       W'(div_by_zero), W'(0));
    check("rstmid_ovf",       W'(overflow), W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (120) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) seen++;
    end
    check("rstmid_no_stale", W'(seen), W'(0));
    run_op(SIX, TWO, THREE, 1'b0, 1'b0, 98, "after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_fixedpoint_div_s
